uart_tx_cfg: RTL and testbench
==============================

UART_TX_CFG -- requirements
Module: uart_tx_cfg

Interface
REQ-001 The block SHALL accept parameter DIV_W, default 16, width of the baud divisor.
REQ-002 The block SHALL accept parameter DATA_W, default 8, maximum data bits per frame (fixed 8 in this generation).
REQ-003 clk  input  1  system clock (50 MHz nominal).
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 baud_div  input  DIV_W  clocks per bit minus one.
REQ-006 data_bits  input  2  data length: 00=5, 01=6, 10=7, 11=8.
REQ-007 parity_mode  input  2  00=none, 01=even, 10=odd, 11=none.
REQ-008 stop2  input  1  1 = two stop bits, 0 = one stop bit.
REQ-009 s_valid  input  1  byte offered.
REQ-010 s_data  input  DATA_W  byte to send; bits above the selected length are ignored.
REQ-011 s_ready  output  1  block can accept a byte.
REQ-012 tx  output  1  serial line, idle high.
REQ-013 busy  output  1  frame in progress.
REQ-014 done  output  1  one-cycle pulse at the end of a frame.

Function
REQ-015 The FSM SHALL have the states IDLE, START, DATA, PARITY and STOP; s_ready SHALL be 1 only in IDLE.
REQ-016 Transfer SHALL occur on a clock edge with s_valid && s_ready; s_data, baud_div, data_bits, parity_mode and stop2 SHALL be captured then and held for the whole frame; later input changes SHALL NOT affect the frame.
REQ-017 tx SHALL be registered; the start bit (0) SHALL appear on tx in the cycle after transfer, with busy=1 from that cycle.
REQ-018 Every bit SHALL last exactly baud_div+1 clocks; the uart_baud_tick counter SHALL restart at transfer; baud_div=0 SHALL give 1-clock bits.
REQ-019 Data SHALL be sent LSB first, N bits, where N comes from data_bits.
REQ-020 The parity bit SHALL follow the data: even = XOR of the N data bits, odd = inverse of that; mode 00/11 SHALL skip PARITY.
REQ-021 STOP SHALL drive 1 for one bit period, or two if stop2 was captured as 1.
REQ-022 done SHALL pulse in the final clock of STOP; the next cycle SHALL be IDLE with busy=0, s_ready=1 and tx=1.
REQ-023 The frame length SHALL be (1+N+P+S)*(baud_div+1) clocks; the minimum gap between back-to-back frames SHALL be one idle clock.
REQ-024 s_valid while s_ready=0 SHALL be held off with no data loss (s_data unchanged until transfer).

Reset
REQ-025 When rst_n is low, the block SHALL immediately set tx=1, s_ready=0, busy=0, done=0, FSM=IDLE, and clear all counters.
REQ-026 s_ready SHALL rise in the first clock after reset deassertion.
REQ-027 Reset mid-frame SHALL abort the frame, with no done pulse.

Configuration
REQ-028 With macro UART_TX_PARITY_EN defined, PARITY SHALL behave per REQ-020.
REQ-029 With UART_TX_PARITY_EN undefined, the PARITY state and its logic SHALL be absent; the parity_mode port SHALL remain but be ignored, so frames are always no-parity.

Structure
REQ-030 The package uart_pkg SHALL hold the FSM state encoding, the parity_mode and data_bits encodings, and the default DIV_W.
REQ-031 The bit timing SHALL live in the sub-module uart_baud_tick (a DIV_W counter with load/restart and a tick output), and this sub-module SHALL be reusable by a future receiver.

Verification
REQ-032 baud_div=433, 8N1, s_data=0xA5 -> tx = 0,1,0,1,0,0,1,0,1,1, each bit 434 clocks; done at clock 4340 after transfer.
REQ-033 baud_div=3, data_bits=10, parity odd, stop2=1, s_data=0x41 -> bits 0,1,0,0,0,0,0,1,1,1,1 (44 clocks); with the macro undefined -> 0,1,0,0,0,0,0,1,1,1 (40 clocks).
REQ-034 data_bits=00, s_data=0xFF, baud_div=1 -> 0,1,1,1,1,1,1 (14 clocks); s_data[7:5] ignored.
REQ-035 s_valid held high for two bytes, baud_div=0, 8N1 -> exactly one tx=1 idle clock between frames; s_ready high only in that clock.
REQ-036 rst_n low at clock 1000 of a baud_div=433 frame -> tx=1 immediately, no done pulse; a new 0x55 frame after reset is correct.
REQ-037 baud_div and data_bits changed mid-frame -> the current frame is unchanged; the next frame uses the new values.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------------
// | uart_pkg -- shared encodings for the UART transmitter and its baud timer.
// | Optional macro UART_TX_PARITY_EN adds the PARITY state. Revision: 1.0
// +---------------------------------------------------------------------------
package uart_pkg;

    localparam int DIV_W_DEFAULT = 16;
    localparam int BITCNT_W      = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } uart_state_e;

    typedef enum logic [1:0] {
        PAR_NONE     = 2'b00,
        PAR_EVEN     = 2'b01,
        PAR_ODD      = 2'b10,
        PAR_NONE_ALT = 2'b11
    } uart_parity_e;

    typedef enum logic [1:0] {
        DB_5 = 2'b00,
        DB_6 = 2'b01,
        DB_7 = 2'b10,
        DB_8 = 2'b11
    } uart_dbits_e;

    // Number of data bits encoded by a data_bits code (5..8).
    function automatic logic [BITCNT_W-1:0] data_len(input logic [1:0] code);
        return BITCNT_W'(code) + BITCNT_W'(5);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`default_nettype none
// +---------------------------------------------------------------------------
// | uart_baud_tick -- bit-period timer: ticks every div_i+1 enabled clocks,
// | restartable from zero. Shared by transmitter and receiver. Revision: 1.0
// +---------------------------------------------------------------------------
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             restart_i,
    input  logic             en_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             tick_o
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;

    assign tick_o = en_i && (cnt_q == div_i);

    always_comb begin
        cnt_d = cnt_q;
        if (restart_i) begin
            cnt_d = '0;
        end else if (tick_o) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_cfg.sv
`default_nettype none
// +---------------------------------------------------------------------------
// | uart_tx_cfg -- configurable UART transmitter (5..8 data bits, 1/2 stop).
// | Parity support only when UART_TX_PARITY_EN is defined. Revision: 1.0
// +---------------------------------------------------------------------------
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int DIV_W  = DIV_W_DEFAULT,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DIV_W-1:0]  baud_div,
    input  logic [1:0]        data_bits,
    input  logic [1:0]        parity_mode,
    input  logic              stop2,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic              tx,
    output logic              busy,
    output logic              done
);

    uart_state_e          state_q, state_d;
    logic                 ready_q, ready_d;
    logic                 tx_q, tx_d;
    logic [DATA_W-1:0]    shreg_q, shreg_d;
    logic [BITCNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic [DIV_W-1:0]     div_q;
    logic [BITCNT_W-1:0]  nbits_q;
    logic                 stop2_q;
    logic [BITCNT_W-1:0]  w_len;
    logic                 w_xfer;
    logic                 w_tick;
    logic                 w_done;
    logic                 w_busy;

    assign w_xfer  = s_valid && ready_q;
    assign w_busy  = (state_q != ST_IDLE);
    assign w_len   = data_len(data_bits);

    assign s_ready = ready_q;
    assign tx      = tx_q;
    assign busy    = w_busy;
    assign done    = w_done;

    uart_baud_tick #(
        .DIV_W (DIV_W)
    ) u_baud (
        .clk       (clk),
        .rst_n     (rst_n),
        .restart_i (w_xfer),
        .en_i      (w_busy),
        .div_i     (div_q),
        .tick_o    (w_tick)
    );

`ifdef UART_TX_PARITY_EN
    logic              par_en_q;
    logic              par_val_q;
    logic [DATA_W-1:0] w_mask;
    logic              w_par_even;

    // Parity covers only the selected data length, so mask off the upper bits.
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < DATA_W; i++) begin
            w_mask[i] = (i < int'(w_len));
        end
    end

    assign w_par_even = ^(s_data & w_mask);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_en_q  <= 1'b0;
            par_val_q <= 1'b0;
        end else if (w_xfer) begin
            par_en_q  <= (parity_mode == PAR_EVEN) || (parity_mode == PAR_ODD);
            par_val_q <= (parity_mode == PAR_ODD) ? ~w_par_even : w_par_even;
        end
    end
`else
    logic unused_parity_mode;
    assign unused_parity_mode = ^parity_mode;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q   <= '0;
            nbits_q <= '0;
            stop2_q <= 1'b0;
        end else if (w_xfer) begin
            div_q   <= baud_div;
            nbits_q <= w_len;
            stop2_q <= stop2;
        end
    end

    // tx_d is the line level for the next cycle, so tx stays a clean register.
    always_comb begin
        state_d    = state_q;
        tx_d       = tx_q;
        shreg_d    = shreg_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        w_done     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (w_xfer) begin
                    state_d   = ST_START;
                    tx_d      = 1'b0;
                    shreg_d   = s_data;
                    bit_cnt_d = '0;
                end
            end
            ST_START: begin
                if (w_tick) begin
                    state_d   = ST_DATA;
                    tx_d      = shreg_q[0];
                    shreg_d   = shreg_q >> 1;
                    bit_cnt_d = BITCNT_W'(1);
                end
            end
            ST_DATA: begin
                if (w_tick) begin
                    if (bit_cnt_q == nbits_q) begin
`ifdef UART_TX_PARITY_EN
                        if (par_en_q) begin
                            state_d = ST_PARITY;
                            tx_d    = par_val_q;
                        end else
`endif
                        begin
                            state_d    = ST_STOP;
                            tx_d       = 1'b1;
                            stop_cnt_d = 1'b0;
                        end
                    end else begin
                        tx_d      = shreg_q[0];
                        shreg_d   = shreg_q >> 1;
                        bit_cnt_d = bit_cnt_q + BITCNT_W'(1);
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (w_tick) begin
                    state_d    = ST_STOP;
                    tx_d       = 1'b1;
                    stop_cnt_d = 1'b0;
                end
            end
`endif
            ST_STOP: begin
                if (w_tick) begin
                    if (stop_cnt_q == stop2_q) begin
                        w_done  = 1'b1;
                        state_d = ST_IDLE;
                        tx_d    = 1'b1;
                    end else begin
                        stop_cnt_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    // Ready is registered so it stays low until the first clock out of reset.
    assign ready_d = (state_d == ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ready_q    <= 1'b0;
            tx_q       <= 1'b1;
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ready_q    <= ready_d;
            tx_q       <= tx_d;
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_cfg.sv
`default_nettype none
// Bench for uart_tx_cfg: frames are predicted from a bit-list model of the
// serial format and compared clock by clock against the tx line.
module tb_uart_tx_cfg;

`ifdef UART_TX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] baud_div = '0;
    logic [1:0]  data_bits = '0;
    logic [1:0]  parity_mode = '0;
    logic        stop2 = 1'b0;
    logic        s_valid = 1'b0;
    logic [7:0]  s_data = '0;
    logic        s_ready, tx, busy, done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_tx_cfg #(.DIV_W(16), .DATA_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .baud_div    (baud_div),
        .data_bits   (data_bits),
        .parity_mode (parity_mode),
        .stop2       (stop2),
        .s_valid     (s_valid),
        .s_data      (s_data),
        .s_ready     (s_ready),
        .tx          (tx),
        .busy        (busy),
        .done        (done)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    // Offer a byte with its configuration; called at a falling edge.
    task automatic offer(input logic [7:0] d, input int div, input logic [1:0] db,
                         input logic [1:0] pm, input logic s2);
        s_data      = d;
        baud_div    = 16'(div);
        data_bits   = db;
        parity_mode = pm;
        stop2       = s2;
        s_valid     = 1'b1;
    endtask

    // Transfer happens at the next rising edge; then the whole frame is compared.
    task automatic expect_frame(input logic [7:0] d, input int div, input logic [1:0] db,
                                input logic [1:0] pm, input logic s2, input bit keep_valid,
                                input logic [7:0] next_d, input int chg_at);
        bit   bits[16];
        int   nb = 0;
        int   n;
        int   len;
        int   tx_bad = 0, ctl_bad = 0, done_cnt = 0, done_at = -1, first_bad = -1;
        logic first_act = 1'b0;
        bit   par;
        n = 5 + int'(db);
        bits[nb] = 1'b0; nb++;
        for (int i = 0; i < n; i++) begin
            bits[nb] = d[i]; nb++;
        end
        if (PAR_EN && (pm == 2'b01 || pm == 2'b10)) begin
            par = 1'b0;
            for (int i = 0; i < n; i++) par = par ^ d[i];
            bits[nb] = (pm == 2'b10) ? ~par : par; nb++;
        end
        bits[nb] = 1'b1; nb++;
        if (s2) begin
            bits[nb] = 1'b1; nb++;
        end
        len = nb * (div + 1);

        @(posedge clk);
        @(negedge clk);
        if (keep_valid) s_data = next_d;
        else s_valid = 1'b0;
        for (int k = 1; k <= len; k++) begin
            if (tx !== bits[(k-1)/(div+1)]) begin
                tx_bad++;
                if (first_bad < 0) begin
                    first_bad = k;
                    first_act = tx;
                end
            end
            if (done === 1'b1) begin
                done_cnt++;
                done_at = k;
            end else if (done !== 1'b0) begin
                done_cnt += 100;
            end
            if (busy !== 1'b1 || s_ready !== 1'b0) ctl_bad++;
            if (k == chg_at) begin
                baud_div    = 16'($urandom);
                data_bits   = 2'($urandom);
                parity_mode = 2'($urandom);
                stop2       = 1'($urandom);
                if (!s_valid) s_data = 8'($urandom);
            end
            @(negedge clk);
        end

        checks++;
        if (tx_bad != 0) begin
            errors++;
            $display("FAIL frame_tx: %0d wrong clocks, first at clock %0d got %b want %b (data=%h div=%0d db=%0d pm=%0d s2=%0b)",
                     tx_bad, first_bad, first_act, bits[(first_bad-1)/(div+1)], d, div, db, pm, s2);
        end
        checks++;
        if (done_cnt != 1 || done_at != len) begin
            errors++;
            $display("FAIL frame_done: got %0d pulses last at clock %0d, want 1 pulse at clock %0d (data=%h)",
                     done_cnt, done_at, len, d);
        end
        checks++;
        if (ctl_bad != 0) begin
            errors++;
            $display("FAIL frame_ctl: busy/s_ready wrong in %0d of %0d clocks, want busy=1 s_ready=0", ctl_bad, len);
        end
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0 || s_ready !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL idle_after: tx=%b busy=%b s_ready=%b done=%b, want 1 0 1 0", tx, busy, s_ready, done);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (tx !== 1'b1 || s_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: tx=%b s_ready=%b busy=%b done=%b, want 1 0 0 0", tx, s_ready, busy, done);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (s_ready !== 1'b1 || tx !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: s_ready=%b tx=%b busy=%b, want 1 1 0", s_ready, tx, busy);
        end
    endtask

    task automatic test_vectors();
        offer(8'hA5, 433, 2'b11, 2'b00, 1'b0);
        expect_frame(8'hA5, 433, 2'b11, 2'b00, 1'b0, 1'b0, 8'h00, -1);
        offer(8'h41, 3, 2'b10, 2'b10, 1'b1);
        expect_frame(8'h41, 3, 2'b10, 2'b10, 1'b1, 1'b0, 8'h00, -1);
        offer(8'hFF, 1, 2'b00, 2'b00, 1'b0);
        expect_frame(8'hFF, 1, 2'b00, 2'b00, 1'b0, 1'b0, 8'h00, -1);
    endtask

    task automatic test_back_to_back();
        logic [7:0] d1, d2;
        d1 = 8'($urandom);
        d2 = 8'($urandom);
        offer(d1, 0, 2'b11, 2'b00, 1'b0);
        expect_frame(d1, 0, 2'b11, 2'b00, 1'b0, 1'b1, d2, -1);
        expect_frame(d2, 0, 2'b11, 2'b00, 1'b0, 1'b0, 8'h00, -1);
    endtask

    task automatic test_random_cfg_change();
        for (int it = 0; it < 24; it++) begin
            logic [7:0] d;
            int         div;
            logic [1:0] db, pm;
            logic       s2;
            d   = 8'($urandom);
            div = int'($urandom_range(0, 6));
            db  = 2'($urandom);
            pm  = 2'($urandom);
            s2  = 1'($urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            offer(d, div, db, pm, s2);
            expect_frame(d, div, db, pm, s2, 1'b0, 8'h00,
                         int'($urandom_range(1, 12 * (div + 1))));
        end
    endtask

    task automatic test_reset_mid_frame();
        int dcount = 0;
        offer(8'hA5, 433, 2'b11, 2'b00, 1'b0);
        @(posedge clk);
        @(negedge clk);
        s_valid = 1'b0;
        for (int k = 1; k < 1000; k++) begin
            if (done !== 1'b0) dcount++;
            @(negedge clk);
        end
        checks++;
        if (tx !== 1'b0) begin
            errors++;
            $display("FAIL pre_reset_tx: tx=%b at clock 1000, want 0 (data bit 1 of A5)", tx);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0 || s_ready !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_async: tx=%b busy=%b s_ready=%b done=%b, want 1 0 0 0", tx, busy, s_ready, done);
        end
        repeat (3) begin
            @(negedge clk);
            if (done !== 1'b0) dcount++;
        end
        checks++;
        if (dcount != 0) begin
            errors++;
            $display("FAIL reset_mid_done: %0d done pulses around aborted frame, want 0", dcount);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (s_ready !== 1'b1 || tx !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_release: s_ready=%b tx=%b, want 1 1", s_ready, tx);
        end
        offer(8'h55, 433, 2'b11, 2'b00, 1'b0);
        expect_frame(8'h55, 433, 2'b11, 2'b00, 1'b0, 1'b0, 8'h00, -1);
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_back_to_back();
        test_random_cfg_change();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
